// File: rtl/rijndael_pkg.sv
// Shared Rijndael definitions: S-box tables, state byte addressing, and the
// SubBytes sequencer state enum.
package rijndael_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Byte k of a state sits MSB-first: bits [statesize-1-8k -: 8].
   // Returns the LSB position of that byte for use with +: selects.
   function automatic int byte_lsb(input int statesize, input int k);
      return statesize - 8 * (k + 1);
   endfunction

endpackage

// File: rtl/rijndael_sbox.sv
// Combinational forward/inverse Rijndael S-box lookup for one byte.
module rijndael_sbox
   import rijndael_pkg::*;
(
   input  logic [7:0] byte_i,
   input  logic       inv_i,
   output logic [7:0] byte_o
);

   assign byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];

endmodule

// File: rtl/rijndael_subbytes_seq.sv
// Byte-serial SubBytes: takes a whole state, substitutes LANES bytes per
// cycle in place through a shared S-box bank, then holds the result until
// downstream takes it.
module rijndael_subbytes_seq
   import rijndael_pkg::*;
#(
   parameter  int NB        = 4,
   parameter  int LANES     = 4,
   localparam int STATESIZE = 32 * NB
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 inv_i,
   input  logic [STATESIZE-1:0] state_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [STATESIZE-1:0] state_o
);

   localparam int NBYTES = 4 * NB;
   localparam int C      = NBYTES / LANES;
   localparam int CW     = (C > 1) ? $clog2(C) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

   generate
      if (!((NB == 4 || NB == 6 || NB == 8) &&
            (LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8) &&
            (NBYTES % LANES == 0))) begin : g_bad_params
         $error("rijndael_subbytes_seq: illegal NB/LANES combination");
      end
   endgenerate

   fsm_e                 fsm_reg, fsm_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic                 inv_reg, inv_next;
   logic [STATESIZE-1:0] state_reg, state_next;
   logic [LANES-1:0][7:0] lane_in;
   logic [LANES-1:0][7:0] lane_out;

   // One S-box per lane; lane gi handles byte cnt*LANES+gi of the group.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_in[gi] = state_reg[byte_lsb(STATESIZE, int'(cnt_reg) * LANES + gi) +: 8];

         rijndael_sbox u_sbox (
            .byte_i (lane_in[gi]),
            .inv_i  (inv_reg),
            .byte_o (lane_out[gi])
         );
      end
   endgenerate

   assign in_ready_o  = (fsm_reg == IDLE);
   assign out_valid_o = (fsm_reg == DONE);
   assign state_o     = state_reg;

   // Next-state and datapath update: load on accept, substitute one group per BUSY cycle.
   always_comb begin
      fsm_next   = fsm_reg;
      cnt_next   = cnt_reg;
      inv_next   = inv_reg;
      state_next = state_reg;
      case (fsm_reg)
         IDLE: begin
            if (in_valid_i) begin
               state_next = state_i;
               inv_next   = inv_i;
               cnt_next   = '0;
               fsm_next   = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < LANES; i++) begin
               state_next[byte_lsb(STATESIZE, int'(cnt_reg) * LANES + i) +: 8] = lane_out[i];
            end
            // Hold the counter on the last group so it never runs past C-1.
            if (cnt_reg == CNT_LAST) begin
               fsm_next = DONE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE: begin
            if (out_ready_i) begin
               fsm_next = IDLE;
            end
         end
         default: fsm_next = IDLE;
      endcase
   end

   // State registers with synchronous reset that also discards any pending result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_reg   <= IDLE;
         cnt_reg   <= '0;
         inv_reg   <= 1'b0;
         state_reg <= '0;
      end else begin
         fsm_reg   <= fsm_next;
         cnt_reg   <= cnt_next;
         inv_reg   <= inv_next;
         state_reg <= state_next;
      end
   end

endmodule

// File: tb/tb_rijndael_subbytes_seq.sv
// Self-checking bench for rijndael_subbytes_seq. Three instances cover
// NB=4/LANES=4, NB=8/LANES=4 and NB=6/LANES=1. Expected results come from an
// S-box built with GF(2^8) inversion plus the affine map.
module tb_rijndael_subbytes_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic         iv_a, inv_a, ir_a, ov_a, or_a;
   logic [127:0] si_a, so_a;
   logic         iv_b, inv_b, ir_b, ov_b, or_b;
   logic [255:0] si_b, so_b;
   logic         iv_c, inv_c, ir_c, ov_c, or_c;
   logic [191:0] si_c, so_c;

   rijndael_subbytes_seq #(.NB(4), .LANES(4)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv_a), .in_ready_o(ir_a), .inv_i(inv_a),
      .state_i(si_a), .out_valid_o(ov_a), .out_ready_i(or_a), .state_o(so_a));
   rijndael_subbytes_seq #(.NB(8), .LANES(4)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv_b), .in_ready_o(ir_b), .inv_i(inv_b),
      .state_i(si_b), .out_valid_o(ov_b), .out_ready_i(or_b), .state_o(so_b));
   rijndael_subbytes_seq #(.NB(6), .LANES(1)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv_c), .in_ready_o(ir_c), .inv_i(inv_c),
      .state_i(si_c), .out_valid_o(ov_c), .out_ready_i(or_c), .state_o(so_c));

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      logic [7:0] s, x;
      s = b; x = b;
      for (int i = 0; i < 4; i++) begin
         x = {x[6:0], x[7]};
         s = s ^ x;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [255:0] ref_state(input logic [255:0] st, input int nb, input logic inv);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < nb; k++)
         r[8*k +: 8] = inv ? inv_tab[st[8*k +: 8]] : fwd_tab[st[8*k +: 8]];
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- instance access ----------------
   function automatic int nbytes_of(input int w);
      return (w == 0) ? 16 : (w == 1) ? 32 : 24;
   endfunction

   function automatic int c_of(input int w);
      return (w == 0) ? 4 : (w == 1) ? 8 : 24;
   endfunction

   function automatic logic [255:0] mask_of(input int w);
      logic [255:0] m;
      m = '0;
      for (int k = 0; k < nbytes_of(w); k++) m[8*k +: 8] = 8'hff;
      return m;
   endfunction

   task automatic drive(input int w, input logic v, input logic iv, input logic [255:0] st, input logic ordy);
      case (w)
         0: begin iv_a = v; inv_a = iv; si_a = st[127:0]; or_a = ordy; end
         1: begin iv_b = v; inv_b = iv; si_b = st;        or_b = ordy; end
         default: begin iv_c = v; inv_c = iv; si_c = st[191:0]; or_c = ordy; end
      endcase
   endtask

   function automatic logic [255:0] get_out(input int w);
      return (w == 0) ? {128'b0, so_a} : (w == 1) ? so_b : {64'b0, so_c};
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 0) ? ov_a : (w == 1) ? ov_b : ov_c;
   endfunction

   function automatic logic get_ir(input int w);
      return (w == 0) ? ir_a : (w == 1) ? ir_b : ir_c;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction: offer, wait for result, optionally stall in DONE
   // with random input noise, then release with a single-cycle out_ready.
   task automatic transact(input int w, input logic [255:0] st, input logic iv, input int hold,
                           input logic noise, input string tag, output logic [255:0] res);
      logic [255:0] exp;
      logic ir_bad, hold_bad;
      int cyc;
      exp = ref_state(st & mask_of(w), nbytes_of(w), iv);
      drive(w, 1'b1, iv, st & mask_of(w), 1'b0);
      check({tag, "_ready_idle"}, get_ir(w), 1);
      @(posedge clk); #1;
      drive(w, 1'b0, 1'b0, '0, 1'b0);
      cyc = 0;
      ir_bad = 1'b0;
      while (!get_ov(w) && cyc < 500) begin
         if (get_ir(w)) ir_bad = 1'b1;
         if (noise) drive(w, 1'($urandom_range(1)), 1'($urandom_range(1)), rand256(), 1'b0);
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, c_of(w));
      check({tag, "_ready_busy"}, ir_bad, 0);
      check({tag, "_ready_done"}, get_ir(w), 0);
      res = get_out(w);
      check({tag, "_data"}, res, exp);
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (noise) drive(w, 1'($urandom_range(1)), 1'($urandom_range(1)), rand256(), 1'b0);
         @(posedge clk); #1;
         if (!get_ov(w) || get_out(w) !== res) hold_bad = 1'b1;
      end
      if (hold > 0) check({tag, "_hold_stable"}, hold_bad, 0);
      drive(w, 1'b0, 1'b0, '0, 1'b1);
      @(posedge clk); #1;
      drive(w, 1'b0, 1'b0, '0, 1'b0);
      check({tag, "_rel_valid"}, get_ov(w), 0);
      check({tag, "_rel_ready"}, get_ir(w), 1);
      $display("txn %s inst=%0d inv=%0b busy=%0d hold=%0d out=%h", tag, w, iv, cyc, hold, res);
   endtask

   initial begin
      logic [255:0] r, r2, v, st;
      logic [255:0] expq [$];
      logic iv;
      int cyc, acc_prev, sent, got;
      bit accept_now;

      rst = 1'b1;
      for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 256; i++) fwd_tab[i] = affine(ginv(8'(i)));
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 3; w++) begin
         check($sformatf("rst%0d_valid", w), get_ov(w), 0);
         check($sformatf("rst%0d_ready", w), get_ir(w), 1);
         check($sformatf("rst%0d_state", w), get_out(w), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // All-zero state -> all 0x63.
      transact(0, '0, 1'b0, 0, 1'b0, "zero", r);
      check("zero_literal", r, {128'b0, {16{8'h63}}});

      // Counting bytes forward, then inverse restores the input.
      v = {128'b0, 128'h000102030405060708090a0b0c0d0e0f};
      transact(0, v, 1'b0, 0, 1'b0, "count_fwd", r);
      check("count_fwd_literal", r, {128'b0, 128'h637c777bf26b6fc53001672bfed7ab76});
      transact(0, r, 1'b1, 0, 1'b0, "count_inv", r2);
      check("count_inv_restore", r2, v);

      // Long backpressure with inputs wiggling during BUSY and DONE.
      transact(0, rand256(), 1'b0, 10, 1'b1, "backpr_fwd", r);
      transact(0, rand256(), 1'b1, 10, 1'b1, "backpr_inv", r);

      // Reset at cnt=2: result discarded, and no accept while reset is high.
      drive(0, 1'b1, 1'b0, rand256(), 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, rand256(), 1'b0);
      @(posedge clk); #1;
      check("midrst_valid", ov_a, 0);
      check("midrst_ready", ir_a, 1);
      check("midrst_state", so_a, 0);
      @(posedge clk); #1;
      check("rst_no_accept_ready", ir_a, 1);
      check("rst_no_accept_state", so_a, 0);
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      transact(0, {128'b0, {16{8'h53}}}, 1'b0, 0, 1'b0, "after_rst", r);
      check("after_rst_literal", r, {128'b0, {16{8'hed}}});

      // Wider states and single-lane configuration.
      transact(1, {32{8'hff}}, 1'b0, 0, 1'b0, "nb8_ff", r);
      check("nb8_ff_literal", r, {32{8'h16}});
      transact(2, rand256(), 1'b0, 2, 1'b1, "nb6_l1_fwd", r);
      transact(2, r, 1'b1, 0, 1'b0, "nb6_l1_inv", r2);

      // Randomized transactions on every instance.
      for (int n = 0; n < 9; n++) begin
         transact(n % 3, rand256(), 1'($urandom_range(1)), $urandom_range(3), 1'($urandom_range(1)),
                  $sformatf("rand%0d", n), r);
      end

      // Back-to-back with in_valid and out_ready held high on NB=4/LANES=4.
      cyc = 0; acc_prev = -1; sent = 0; got = 0;
      st = rand256() & mask_of(0);
      iv = 1'($urandom_range(1));
      drive(0, 1'b1, iv, st, 1'b1);
      while (got < 6 && cyc < 400) begin
         accept_now = ir_a && iv_a;
         if (ov_a) begin
            check("b2b_queue_nonempty", expq.size() != 0, 1);
            if (expq.size() != 0) check("b2b_data", get_out(0), expq.pop_front());
            got++;
         end
         if (accept_now) begin
            expq.push_back(ref_state(st, 16, iv));
            if (acc_prev >= 0) check("b2b_gap", cyc - acc_prev, 6);
            acc_prev = cyc;
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (accept_now) begin
            if (sent < 6) begin
               st = rand256() & mask_of(0);
               iv = 1'($urandom_range(1));
               drive(0, 1'b1, iv, st, 1'b1);
            end else begin
               drive(0, 1'b0, 1'b0, '0, 1'b1);
            end
         end
      end
      drive(0, 1'b0, 1'b0, '0, 1'b0);
      check("b2b_sent", sent, 6);
      check("b2b_got", got, 6);
      check("b2b_leftover", expq.size(), 0);
      $display("txn b2b inst=0 sent=%0d got=%0d cycles=%0d", sent, got, cyc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rijndael_subbytes_seq.md
Name: rijndael_subbytes_seq

Overview:
- Byte-serial SubBytes stage. It sits directly upstream of the combinational ShiftRows stage in the iterative Rijndael datapath.
- It accepts a full state over a valid/ready handshake and substitutes LANES bytes per cycle through a shared S-box bank.
- It presents the substituted state on an output valid/ready handshake.
- It supports the forward (encrypt) and inverse (decrypt) S-box, selected per state.

Parameters:
- NB, 4: state width in 32-bit columns. Legal values are 4, 6, 8.
- LANES, 4: S-box instances, i.e. bytes processed per cycle. Must divide 4*NB. Legal values are 1, 2, 4, 8.
- STATESIZE, 32*NB: localparam, state width in bits.

Ports:
- clk_i  in  1  clock. All logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  a state is offered on state_i.
- in_ready_o  out  1  block can accept a state.
- inv_i  in  1  0 selects the forward S-box, 1 selects the inverse. Sampled on accept.
- state_i  in  STATESIZE  input state. Byte k = state_i[STATESIZE-1-8k -: 8], i.e. row k%4, column k/4.
- out_valid_o  out  1  the result on state_o is valid.
- out_ready_i  in  1  downstream takes the result.
- state_o  out  STATESIZE  substituted state, same byte mapping as state_i.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- On reset: state register, counter, stored inv, and state_o are all cleared to 0. out_valid_o = 0.
- in_ready_o = (fsm == IDLE), combinational. out_valid_o = (fsm == DONE).
- No handshake is honoured in a cycle where rst_i = 1. Reset takes priority over everything.
- IDLE: if in_valid_i && in_ready_o at the edge:
  - load state_i into the working register;
  - latch inv_i;
  - set cnt = 0;
  - go to BUSY.
- BUSY: each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by S(byte) or InvS(byte).
  - cnt increments each cycle.
  - When cnt == C-1, where C = 4*NB/LANES, go to DONE.
  - inv_i and state_i are ignored while in BUSY.
- DONE: state_o holds the full substituted state, stable.
  - If out_ready_i = 1 at the edge, go to IDLE. No output data changes.
  - Otherwise hold. Backpressure may last indefinitely.
- Latency: accept at edge t, out_valid_o is high after edge t+C. Examples: NB=4/LANES=4 gives C=4; NB=8/LANES=4 gives C=8; NB=4/LANES=16 is illegal.
- Throughput: one state per C+2 cycles. No overlap of accept with busy or done.
- state_o is driven from the working register. Contents in IDLE/BUSY are don't-care for consumers but must be deterministic: the partially substituted register.
- cnt width is $clog2(C), minimum 1. It never wraps past C-1.
- Reset mid-BUSY or mid-DONE: return to IDLE next cycle with out_valid_o = 0. The pending result is discarded.
- Elaboration-time assertion: NB in {4,6,8}, and 4*NB % LANES == 0.

Decomposition:
- rijndael_pkg:
  - SBOX and INV_SBOX 256x8 constant tables (FIPS-197);
  - the state-byte index helper function;
  - the fsm_e enum (IDLE/BUSY/DONE).
- Sub-module rijndael_sbox: combinational, ports byte_i, inv_i, byte_o. It is instantiated LANES times and reused by future key-expansion and round logic.

Test Plan:
- NB=4, LANES=4, inv=0, state 00..00 -> after 4 busy cycles out_valid_o=1, state_o = 0x6363..63 (128 bits). in_ready_o low during BUSY and DONE.
- NB=4, inv=0, state 00 01 02 .. 0F -> 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76. Then the same vector with inv=1 on that output -> 00 01 .. 0F restored.
- Backpressure: out_ready_i held 0 for 10 cycles in DONE -> state_o and out_valid_o stable. Single-cycle out_ready_i -> IDLE, in_ready_o=1 next cycle. Input changing during BUSY has no effect.
- Reset mid-BUSY at cnt=2 -> next cycle IDLE, out_valid_o=0, state_o=0. A subsequent state 53..53 yields ED..ED.
- NB=8, LANES=4, state FF repeated -> exactly 8 busy cycles, state_o = 0x16 repeated 32 bytes. NB=6, LANES=1 -> 24 busy cycles, correct result.
- Back-to-back: in_valid_i held high with out_ready_i=1 -> accepts spaced exactly C+2 cycles apart, results in order, no dropped or duplicated states.
